// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: line-atomic round-robin arbiter that shares one
// AXI-stream UART transmitter input between N_SRC byte streams.
module uart_tx_arbiter #(
    parameter int                    N_SRC        = 2,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] EOL_CHAR     = DATA_WIDTH'('h0A),
    parameter int                    HOLD_TIMEOUT = 1024
) (
    input  logic                          clk_p,
    input  logic                          reset,
    input  logic [N_SRC*DATA_WIDTH-1:0]   s_tdata,
    input  logic [N_SRC-1:0]              s_tvalid,
    input  logic [N_SRC-1:0]              s_tlast,
    output logic [N_SRC-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [N_SRC-1:0]              grant,
    output logic                          active,
    output logic                          timeout_evt
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TERM =
        CNT_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_SRC - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_owner_nx;
    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      w_last_nx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic                  r_tevt;
    logic                  w_tevt_nx;
    logic [IDX_W-1:0]      w_pick;
    logic [DATA_WIDTH-1:0] w_src [N_SRC];
    logic                  w_m_tvalid;
    logic [N_SRC-1:0]      w_s_tready;
    logic [N_SRC-1:0]      w_grant;
    logic                  w_xfer;
    logic                  w_eol;

    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        f_wrap = IDX_W'(v % N_SRC);
    endfunction

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign w_src[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan downwards so the nearest requester after r_last wins.
    always_comb begin
        w_pick = r_last;
        for (int k = N_SRC; k >= 1; k--) begin
            if (s_tvalid[f_wrap(int'(r_last) + k)]) begin
                w_pick = f_wrap(int'(r_last) + k);
            end
        end
    end

    assign m_tdata = w_src[r_owner];
    assign w_eol   = (w_src[r_owner] == EOL_CHAR) || s_tlast[r_owner];
    assign w_xfer  = w_m_tvalid & m_tready;

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        w_tevt_nx  = 1'b0;
        w_m_tvalid = 1'b0;
        w_s_tready = '0;
        w_grant    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (|s_tvalid) begin
                    w_state_nx = S_GRANT;
                    w_owner_nx = w_pick;
                    w_cnt_nx   = '0;
                end
            end
            S_GRANT: begin
                w_grant[r_owner]    = 1'b1;
                w_m_tvalid          = s_tvalid[r_owner];
                w_s_tready[r_owner] = m_tready;
                if (w_xfer && w_eol) begin
                    w_state_nx = S_IDLE;
                    w_last_nx  = r_owner;
                end else if (s_tvalid[r_owner]) begin
                    w_cnt_nx = '0;
                end else if (HOLD_TIMEOUT > 0 && r_cnt == TERM) begin
                    w_state_nx = S_IDLE;
                    w_last_nx  = r_owner;
                    w_tevt_nx  = 1'b1;
                end else if (r_cnt != CMAX) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= LAST_INIT;
            r_cnt   <= '0;
            r_tevt  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
            r_tevt  <= w_tevt_nx;
        end
    end

    // Reset blocks handshakes immediately, before the first reset edge.
    assign m_tvalid    = reset & w_m_tvalid;
    assign s_tready    = w_s_tready & {N_SRC{reset}};
    assign grant       = w_grant & {N_SRC{reset}};
    assign active      = reset & (r_state == S_GRANT);
    assign timeout_evt = reset & r_tevt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random streams checked by a per-source
// byte scoreboard and a cycle-level model of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N    = 2;
    localparam int HOLD = 16;
    localparam logic [7:0] EOL = 8'h0A;

    logic            clk_p = 1'b0;
    logic            reset;
    logic [N*8-1:0]  s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic            active;
    logic            timeout_evt;

    uart_tx_arbiter #(
        .N_SRC(N), .DATA_WIDTH(8), .EOL_CHAR(EOL), .HOLD_TIMEOUT(HOLD)
    ) dut (
        .clk_p(clk_p), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .active(active), .timeout_evt(timeout_evt)
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         g;
    } item_t;

    item_t      txq  [N][$];
    logic [7:0] expq [N][$];
    int         wt   [N];
    int         gapa [N];
    int         mode;
    int         test_id;
    int         hang_cnt;
    logic       done_req;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return last;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic int idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Source drivers and m_tready pattern.
    initial begin
        logic [N-1:0] acc;
        int rcnt;
        item_t it;
        rcnt = 0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
        for (int i = 0; i < N; i++) begin wt[i] = 0; gapa[i] = 0; end
        forever begin
            @(negedge clk_p);
            acc = s_tvalid & s_tready;
            @(posedge clk_p);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                    wt[i]       = gapa[i];
                end
                if (!s_tvalid[i]) begin
                    if (wt[i] > 0) wt[i]--;
                    else if (txq[i].size() > 0) begin
                        it = txq[i].pop_front();
                        s_tdata[i*8 +: 8] = it.d;
                        s_tlast[i]  = it.l;
                        s_tvalid[i] = 1'b1;
                        gapa[i]     = it.g;
                        expq[i].push_back(it.d);
                    end
                end
            end
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (rcnt % 4 == 0);
                default: m_tready = 1'($urandom % 2);
            endcase
            rcnt++;
        end
    end

    // Monitor: scoreboard plus arbitration model.
    initial begin
        logic [N-1:0] p_grant, p_valid, exp_g;
        logic p_rst, rel_exp, to_exp, p_stall;
        logic [7:0] p_data;
        int last_own, idle_run, cyc, last_xfer, gi;
        p_grant = '0; p_valid = '0; p_rst = 1'b0; rel_exp = 1'b0;
        to_exp = 1'b0; p_stall = 1'b0; p_data = '0;
        last_own = N - 1; idle_run = 0; cyc = 0; last_xfer = 0;
        forever begin
            @(negedge clk_p);
            cyc++;
            if (done_req) begin
                chk("drain_timeouts", hang_cnt, 0);
                for (int i = 0; i < N; i++) chk("sb_leftover", expq[i].size(), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (!reset) begin
                chk("rst_grant", grant, 0);
                chk("rst_m_tvalid", m_tvalid, 0);
                chk("rst_s_tready", s_tready, 0);
                chk("rst_active", active, 0);
                chk("rst_timeout_evt", timeout_evt, 0);
                last_own = N - 1; idle_run = 0;
                p_grant = '0; p_valid = '0; p_rst = 1'b0;
                rel_exp = 1'b0; to_exp = 1'b0; p_stall = 1'b0;
            end else begin
                if (!p_rst) exp_g = '0;
                else if (p_grant == '0)
                    exp_g = (p_valid != '0) ? oh(pick(p_valid, last_own)) : '0;
                else if (rel_exp || to_exp) exp_g = '0;
                else exp_g = p_grant;
                chk("grant", grant, exp_g);
                chk("timeout_evt", timeout_evt, to_exp);
                if (p_grant != '0 && exp_g == '0) last_own = idx(p_grant);
                if (p_grant == '0) idle_run = 0;
                chk("active", active, grant != '0);
                gi = idx(grant);
                chk("m_tvalid", m_tvalid, (grant & s_tvalid) != '0);
                chk("s_tready", s_tready, grant & {N{m_tready}});
                if (m_tvalid) chk("m_tdata_route", m_tdata, s_tdata[gi*8 +: 8]);
                if (p_stall) chk("stall_stable", {m_tvalid, m_tdata}, {1'b1, p_data});
                rel_exp = 1'b0;
                if (m_tvalid && m_tready) begin
                    if (expq[gi].size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_byte: got %0h from src%0d, expected none",
                                 m_tdata, gi);
                    end else chk("sb_byte", m_tdata, expq[gi].pop_front());
                    rel_exp = (m_tdata == EOL) || s_tlast[gi];
                    last_xfer = cyc;
                end
                if (grant != '0) idle_run = s_tvalid[gi] ? 0 : idle_run + 1;
                to_exp = (grant != '0) && (idle_run == HOLD);
                if (timeout_evt && test_id == 5)
                    chk("timeout_delay", cyc - last_xfer, HOLD + 1);
                p_grant = grant; p_valid = s_tvalid; p_rst = 1'b1;
                p_stall = m_tvalid && !m_tready; p_data = m_tdata;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_p);
        #1;
    endtask

    task automatic push_b(input int s, input logic [7:0] d,
                          input logic l, input int g);
        item_t it;
        it.d = d; it.l = l; it.g = g;
        txq[s].push_back(it);
    endtask

    task automatic push_str(input int s, input string str);
        for (int k = 0; k < str.len(); k++) push_b(s, str[k], 1'b0, 0);
    endtask

    task automatic wait_grant(input logic [N-1:0] g);
        int n;
        n = 0;
        while (grant !== g && n < 500) begin @(negedge clk_p); n++; end
        if (grant !== g) hang_cnt++;
    endtask

    function automatic logic idle_now();
        logic r;
        r = (s_tvalid == '0) && (grant == '0);
        for (int i = 0; i < N; i++) r = r && txq[i].size() == 0 && wt[i] == 0;
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin step(1); n++; end while (!idle_now() && n < budget);
        if (!idle_now()) hang_cnt++;
        step(2);
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b0; mode = 0; test_id = 0; hang_cnt = 0; done_req = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);

        test_id = 1;
        push_str(0, "hi\n");
        wait_idle(200);

        test_id = 2;
        push_str(0, "ab\n");
        wait_grant(2'b01);
        step(1);
        push_str(1, "s\n");
        wait_idle(200);

        test_id = 3;
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < N; s++) begin
                push_b(s, 8'h14, 1'b0, 0);
                push_b(s, EOL, 1'b0, 0);
            end
        end
        wait_idle(300);

        test_id = 4;
        mode = 1;
        push_str(0, "xyz\n");
        wait_idle(300);

        test_id = 5;
        mode = 0;
        push_b(0, "a", 1'b0, 40);
        wait_grant(2'b01);
        step(1);
        push_str(1, "z\n");
        wait_idle(300);

        test_id = 6;
        mode = 1;
        push_str(1, "abcdefgh\n");
        wait_grant(2'b10);
        step(3);
        push_str(0, "q\n");
        step(4);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        wait_idle(500);

        test_id = 7;
        mode = 2;
        for (int k = 0; k < 200; k++) begin
            for (int s = 0; s < N; s++) begin
                d = ($urandom % 8 == 0) ? EOL : 8'(8'h20 + $urandom % 64);
                push_b(s, d, 1'($urandom % 10 == 0),
                       ($urandom % 6 == 0) ? int'($urandom_range(0, 24)) : 0);
            end
        end
        wait_idle(20000);

        done_req = 1'b1;
        step(5);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
